wb_initiator: RTL and testbench
===============================

// Module: wb_initiator
// PURPOSE
//   Wishbone classic single-transfer bus master (initiator); the bus-side counterpart of our
//   memory-mapped peripherals (gpio etc.). Accepts one 32-bit read/write command on a
//   valid/ready port, runs it on the bus, returns one response with data and status.
//   Handles retry (rty), error (err) and timeout. Feeds the SoC interconnect from the core LSU.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max stb_o cycles per attempt without termination; 0 disables timeout
//   MAX_RETRIES     3    rty terminations tolerated before failing (attempts = MAX_RETRIES+1)
//   RETRY_GAP       1    cycles cyc_o/stb_o held low between attempts (>=1)
// PORTS
//   clk_i        in   1   clock, all logic on rising edge
//   rst_ni       in   1   asynchronous active-low reset
//   req_valid_i  in   1   command valid
//   req_ready_o  out  1   command accepted when valid&ready at clock edge
//   req_we_i     in   1   1 = write, 0 = read
//   req_adr_i    in   32  byte address
//   req_sel_i    in   4   byte selects
//   req_dat_i    in   32  write data
//   rsp_valid_o  out  1   one-cycle response pulse
//   rsp_dat_o    out  32  read data (0 for writes and failed transfers)
//   rsp_code_o   out  2   00 OK, 01 BUSERR, 10 RETRY exhausted, 11 TIMEOUT
//   cyc_o, stb_o out  1   Wishbone cycle / strobe
//   we_o         out  1   Wishbone write enable
//   adr_o        out  32  Wishbone address
//   sel_o        out  4   Wishbone byte selects
//   dat_o        out  32  Wishbone write data
//   dat_i        in   32  Wishbone read data
//   ack_i, err_i, rty_i in 1  Wishbone terminations (may be combinational from stb_o)
// BEHAVIOUR
//   Reset (async, rst_ni=0): state IDLE; cyc_o=stb_o=we_o=0, adr_o=sel_o=dat_o=0,
//     rsp_valid_o=0, rsp_dat_o=0, rsp_code_o=00, retry/timer counters 0. Takes effect
//     immediately mid-transfer; aborted transfer produces no response.
//   All bus and rsp outputs are registered. req_ready_o = (state==IDLE) && rst_ni.
//   States: IDLE, ACTIVE, BACKOFF.
//   IDLE: on valid&ready, latch we/adr/sel/dat to bus outputs, cyc_o=stb_o=1 next cycle,
//     retry_cnt=0, timer=0 -> ACTIVE.
//   ACTIVE: terminations sampled each edge; priority ack > err > rty (multi-assert legal).
//     ack: capture dat_i if read, code 00 -> IDLE.  err: code 01 -> IDLE.
//     rty: retry_cnt==MAX_RETRIES -> code 10, IDLE; else retry_cnt++, timer=0 -> BACKOFF.
//     none: timer++; if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 -> code 11, IDLE.
//     Leaving ACTIVE: cyc_o=stb_o=0 next cycle; rsp_valid_o=1 for exactly that one cycle
//     when going to IDLE.
//   BACKOFF: cyc_o=stb_o=0 for RETRY_GAP cycles, then re-assert with unchanged
//     adr/sel/dat/we -> ACTIVE.
//   adr_o/sel_o/dat_o/we_o stable whenever cyc_o=1; hold last value while idle.
//   Latency: zero-wait slave -> stb_o high 1 cycle, rsp_valid_o 2 cycles after acceptance.
//   req_ready_o is high in the rsp_valid_o cycle: back-to-back transfers, 2 cycles each.
//   Counters: timer width clog2(TIMEOUT_CYCLES+1), retry_cnt width clog2(MAX_RETRIES+1);
//     neither wraps.
//   req_valid_i while not ready: ignored, requester must hold.
//   ack_i/err_i/rty_i while cyc_o=0: ignored.
// TESTING
//   1 Read adr 0x0, comb-ack slave returns 0x0000_A500 -> stb_o 1 cycle, rsp 2 cycles
//     after accept, rsp_dat_o 0x0000_A500, code 00.
//   2 Write adr 0x10 sel 0xF dat 0x5A, 3 wait states -> cyc/stb high 4 cycles, outputs
//     stable, code 00, rsp_dat_o 0.
//   3 MAX_RETRIES=3: rty,rty,ack -> 2 gaps of RETRY_GAP low cycles, code 00;
//     4x rty -> 4 attempts, code 10.
//   4 TIMEOUT_CYCLES=8, silent slave -> stb_o high 8 cycles, drops, code 11.
//   5 err -> code 01; ack+err same cycle -> code 00; back-to-back reads, one every 2 cycles.
//   6 rst_ni low during ACTIVE -> cyc_o/stb_o 0 without clock, no rsp_valid_o;
//     next request after release completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic single-transfer bus initiator
//
// Takes one 32-bit read or write command on a valid/ready port, runs it as a
// Wishbone classic cycle, and returns a single-cycle response with data and status.
// Retry terminations are re-issued after a gap of idle bus cycles. An attempt that
// is never terminated is given up after a bounded number of strobe cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  strobe cycles per attempt before giving up (0 = wait forever)
//   MAX_RETRIES     rty terminations tolerated before reporting failure
//   RETRY_GAP       cycles cyc_o/stb_o stay low between attempts (>= 1)
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       command handshake
//   req_we_i, req_adr_i,
//   req_sel_i, req_dat_i            command: direction, byte address, byte selects, write data
//   rsp_valid_o                     one-cycle response pulse
//   rsp_dat_o                       read data (0 for writes and failed transfers)
//   rsp_code_o                      00 OK, 01 BUSERR, 10 RETRY exhausted, 11 TIMEOUT
//   cyc_o, stb_o, we_o, adr_o,
//   sel_o, dat_o                    Wishbone master outputs (all registered)
//   dat_i, ack_i, err_i, rty_i      Wishbone slave read data and terminations

module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned RETRY_GAP      = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_dat_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_code_o,

    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    // Counter widths never drop below one bit so degenerate parameter values still build.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);
    localparam logic [GW-1:0] GAP_LAST   = GW'((RETRY_GAP == 0) ? 0 : RETRY_GAP - 1);
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_BUSERR  = 2'b01;
    localparam logic [1:0] CODE_RETRY   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          bus, bus_n;          // drives both cyc_o and stb_o (single transfers only)
    logic          we, we_n;
    logic [31:0]   adr, adr_n;
    logic [3:0]    sel, sel_n;
    logic [31:0]   wdat, wdat_n;
    logic          rsp_valid, rsp_valid_n;
    logic [31:0]   rsp_dat, rsp_dat_n;
    logic [1:0]    rsp_code, rsp_code_n;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] retry_cnt, retry_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            bus       <= 1'b0;
            we        <= 1'b0;
            adr       <= '0;
            sel       <= '0;
            wdat      <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_code  <= CODE_OK;
            timer     <= '0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            bus       <= bus_n;
            we        <= we_n;
            adr       <= adr_n;
            sel       <= sel_n;
            wdat      <= wdat_n;
            rsp_valid <= rsp_valid_n;
            rsp_dat   <= rsp_dat_n;
            rsp_code  <= rsp_code_n;
            timer     <= timer_n;
            retry_cnt <= retry_cnt_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        bus_n       = bus;
        we_n        = we;
        adr_n       = adr;
        sel_n       = sel;
        wdat_n      = wdat;
        timer_n     = timer;
        retry_cnt_n = retry_cnt;
        gap_cnt_n   = gap_cnt;
        // Response fields are only meaningful in the pulse cycle; they read 0 otherwise.
        rsp_valid_n = 1'b0;
        rsp_dat_n   = '0;
        rsp_code_n  = CODE_OK;

        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    we_n        = req_we_i;
                    adr_n       = req_adr_i;
                    sel_n       = req_sel_i;
                    wdat_n      = req_dat_i;
                    bus_n       = 1'b1;
                    timer_n     = '0;
                    retry_cnt_n = '0;
                    state_n     = ACTIVE;
                end
            end

            ACTIVE: begin
                if (ack_i) begin
                    bus_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_dat_n   = we ? 32'h0 : dat_i;
                    rsp_code_n  = CODE_OK;
                    state_n     = IDLE;
                end else if (err_i) begin
                    bus_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_code_n  = CODE_BUSERR;
                    state_n     = IDLE;
                end else if (rty_i) begin
                    bus_n = 1'b0;
                    if (retry_cnt == RETRY_LAST) begin
                        rsp_valid_n = 1'b1;
                        rsp_code_n  = CODE_RETRY;
                        state_n     = IDLE;
                    end else begin
                        retry_cnt_n = retry_cnt + RW'(1);
                        timer_n     = '0;
                        gap_cnt_n   = '0;
                        state_n     = BACKOFF;
                    end
                end else begin
                    if (TIMEOUT_EN && timer == TIMER_LAST) begin
                        bus_n       = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_code_n  = CODE_TIMEOUT;
                        state_n     = IDLE;
                    end else if (timer != {TW{1'b1}}) begin
                        // Saturating so an unbounded wait never wraps the counter.
                        timer_n = timer + TW'(1);
                    end
                end
            end

            BACKOFF: begin
                if (gap_cnt == GAP_LAST) begin
                    bus_n   = 1'b1;
                    timer_n = '0;
                    state_n = ACTIVE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end

            default: begin
                bus_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state == IDLE) && rst_ni;
    assign cyc_o       = bus;
    assign stb_o       = bus;
    assign we_o        = we;
    assign adr_o       = adr;
    assign sel_o       = sel;
    assign dat_o       = wdat;
    assign rsp_valid_o = rsp_valid;
    assign rsp_dat_o   = rsp_dat;
    assign rsp_code_o  = rsp_code;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - self-checking bench for wb_initiator

module tb_wb_initiator;

    localparam int T = 8;
    localparam int MAXR = 3;
    localparam int G = 2;

    // Slave behaviour per attempt: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err, 5 err+rty, 6 ack+rty
    typedef struct {
        logic            we;
        logic [31:0]     adr;
        logic [3:0]      sel;
        logic [31:0]     dat;
        logic [31:0]     rdata;
        int              wait_n;
        logic [3:0][2:0] kinds;
        logic [1:0]      e_code;
        logic [31:0]     e_dat;
        int              e_k;
        int              e_stb;
        int              e_att;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_dat = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_code_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(MAXR), .RETRY_GAP(G)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_sel_i(req_sel), .req_dat_i(req_dat),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_code_o(rsp_code_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    // Scripted slave: terminates attempt s_att after cfg_wait wait states.
    int              cfg_wait = 0;
    logic [3:0][2:0] cfg_kinds = '0;
    logic [31:0]     cfg_rdata = '0;
    bit              noise_en = 1'b0;
    logic            noise = 1'b0;
    int              s_cnt, s_att;
    logic [2:0]      kind;
    logic            term, k_ack, k_err, k_rty;

    always @(negedge clk) noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

    always_comb begin
        kind  = (s_att < 4) ? cfg_kinds[s_att] : 3'd3;
        term  = stb_o && (s_cnt == cfg_wait);
        k_ack = term && (kind == 3'd0 || kind == 3'd4 || kind == 3'd6);
        k_err = term && (kind == 3'd1 || kind == 3'd4 || kind == 3'd5);
        k_rty = term && (kind == 3'd2 || kind == 3'd5 || kind == 3'd6);
        ack_i = k_ack | (!cyc_o && noise);
        err_i = k_err | (!cyc_o && noise);
        rty_i = k_rty | (!cyc_o && noise);
        dat_i = k_ack ? cfg_rdata : 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            s_cnt <= 0;
            s_att <= 0;
        end else begin
            s_cnt <= stb_o ? s_cnt + 1 : 0;
            if (rsp_valid_o) s_att <= 0;
            else if (k_rty && !k_ack && !k_err) s_att <= s_att + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][2:0] mk(input int k0, input int k1, input int k2, input int k3);
        logic [3:0][2:0] r;
        r[0] = 3'(k0); r[1] = 3'(k1); r[2] = 3'(k2); r[3] = 3'(k3);
        return r;
    endfunction

    function automatic vec_t mkv(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat, input logic [31:0] rdata, input int wait_n,
                                 input logic [3:0][2:0] kinds, input logic [1:0] e_code,
                                 input logic [31:0] e_dat, input int e_k, input int e_stb,
                                 input int e_att);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.rdata = rdata; v.wait_n = wait_n;
        v.kinds = kinds; v.e_code = e_code; v.e_dat = e_dat; v.e_k = e_k; v.e_stb = e_stb;
        v.e_att = e_att;
        return v;
    endfunction

    // Reference: walk the attempts, each costs wait_n+1 strobe cycles (or T if never
    // terminated in time); each retried attempt adds G idle cycles. Response shows up
    // on the negedge after the last strobe cycle.
    function automatic void model(inout vec_t v);
        int gaps = 0;
        logic [2:0] kd;
        v.e_stb = 0; v.e_att = 0; v.e_code = 2'b00; v.e_dat = 32'h0;
        for (int a = 0; a <= MAXR; a++) begin
            kd = v.kinds[a];
            v.e_att++;
            if (kd == 3'd3 || v.wait_n >= T) begin
                v.e_stb += T; v.e_code = 2'b11;
                break;
            end
            v.e_stb += v.wait_n + 1;
            if (kd == 3'd0 || kd == 3'd4 || kd == 3'd6) begin
                v.e_code = 2'b00; v.e_dat = v.we ? 32'h0 : v.rdata;
                break;
            end
            if (kd == 3'd1 || kd == 3'd5) begin
                v.e_code = 2'b01;
                break;
            end
            if (a == MAXR) begin
                v.e_code = 2'b10;
                break;
            end
            gaps++;
        end
        v.e_k = v.e_stb + gaps * G + 1;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int   k = 0, stb_cnt = 0, att = 0;
        bit   got = 0, hold_ok = 1, prev = 0;
        logic [1:0]  code = '0;
        logic [31:0] rdat = '0;
        logic        cyc_at_rsp = 1'b1;
        cfg_wait = v.wait_n; cfg_kinds = v.kinds; cfg_rdata = v.rdata;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_sel = v.sel; req_dat = v.dat;
        #1 check({nm, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; req_adr = ~v.adr; req_dat = ~v.dat;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (stb_o) begin
                stb_cnt++;
                if (!prev) att++;
            end
            prev = stb_o;
            if (cyc_o && !(stb_o && adr_o == v.adr && sel_o == v.sel && dat_o == v.dat
                           && we_o == v.we)) hold_ok = 0;
            if (rsp_valid_o) begin
                got = 1; k = i; code = rsp_code_o; rdat = rsp_dat_o; cyc_at_rsp = cyc_o;
                break;
            end
        end
        check({nm, "_rsp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({nm, "_code"}, 32'(code), 32'(v.e_code));
            check({nm, "_rdat"}, rdat, v.e_dat);
            check({nm, "_latency"}, 32'(k), 32'(v.e_k));
            check({nm, "_stb_cycles"}, 32'(stb_cnt), 32'(v.e_stb));
            check({nm, "_attempts"}, 32'(att), 32'(v.e_att));
            check({nm, "_bus_hold"}, 32'(hold_ok), 32'd1);
            check({nm, "_cyc_dropped"}, 32'(cyc_at_rsp), 32'd0);
            check({nm, "_adr_held"}, adr_o, v.adr);
            @(negedge clk);
            check({nm, "_pulse_end"}, 32'(rsp_valid_o), 32'd0);
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int acc[$], rsp[$];
        bit seen;

        tbl.push_back(mkv(0, 32'h0,  4'hF, 32'h0,  32'h0000_A500, 0, mk(0,0,0,0), 2'b00, 32'h0000_A500, 2, 1, 1));
        tbl.push_back(mkv(1, 32'h10, 4'hF, 32'h5A, 32'h1234_5678, 3, mk(0,0,0,0), 2'b00, 32'h0, 5, 4, 1));
        tbl.push_back(mkv(0, 32'h20, 4'h3, 32'h0,  32'hCAFE_0001, 0, mk(2,2,0,0), 2'b00, 32'hCAFE_0001, 8, 3, 3));
        tbl.push_back(mkv(0, 32'h24, 4'hF, 32'h0,  32'hCAFE_0002, 0, mk(2,2,2,2), 2'b10, 32'h0, 11, 4, 4));
        tbl.push_back(mkv(0, 32'h28, 4'hF, 32'h0,  32'hCAFE_0003, 0, mk(2,2,2,0), 2'b00, 32'hCAFE_0003, 11, 4, 4));
        tbl.push_back(mkv(0, 32'h30, 4'hF, 32'h0,  32'h1,        0, mk(3,3,3,3), 2'b11, 32'h0, 9, 8, 1));
        tbl.push_back(mkv(0, 32'h34, 4'h1, 32'h0,  32'h2,        1, mk(1,0,0,0), 2'b01, 32'h0, 3, 2, 1));
        tbl.push_back(mkv(0, 32'h38, 4'hF, 32'h0,  32'h0BAD_F00D, 0, mk(4,0,0,0), 2'b00, 32'h0BAD_F00D, 2, 1, 1));
        tbl.push_back(mkv(0, 32'h3C, 4'hF, 32'h0,  32'h7777_0007, 7, mk(0,0,0,0), 2'b00, 32'h7777_0007, 9, 8, 1));
        tbl.push_back(mkv(0, 32'h40, 4'hF, 32'h0,  32'h8,        8, mk(0,0,0,0), 2'b11, 32'h0, 9, 8, 1));
        tbl.push_back(mkv(1, 32'h44, 4'hC, 32'h99, 32'h9,        0, mk(5,0,0,0), 2'b01, 32'h0, 2, 1, 1));
        tbl.push_back(mkv(0, 32'h48, 4'hF, 32'h0,  32'hA,        2, mk(2,1,0,0), 2'b01, 32'h0, 9, 6, 2));
        tbl.push_back(mkv(1, 32'h4C, 4'hF, 32'h11, 32'hB,        0, mk(6,0,0,0), 2'b00, 32'h0, 2, 1, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", 32'(cyc_o), 0);
        check("rst_stb", 32'(stb_o), 0);
        check("rst_we", 32'(we_o), 0);
        check("rst_adr", adr_o, 0);
        check("rst_sel", 32'(sel_o), 0);
        check("rst_dat", dat_o, 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_rsp_dat", rsp_dat_o, 0);
        check("rst_rsp_code", 32'(rsp_code_o), 0);
        check("rst_ready_low", 32'(req_ready), 0);
        rst_ni = 1'b1;
        #1 check("rst_ready_high", 32'(req_ready), 1);

        for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back reads with valid held: accepts every 2 cycles, response 2 after accept
        cfg_wait = 0; cfg_kinds = mk(0,0,0,0); cfg_rdata = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h100; req_sel = 4'hF;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid_o) begin
                rsp.push_back(i);
                check($sformatf("b2b_rdat%0d", rsp.size()), rsp_dat_o, 32'h1111_2222);
            end
            if (req_valid && req_ready) acc.push_back(i);
            @(posedge clk);
            #1 if (acc.size() == 3) req_valid = 1'b0;
        end
        check("b2b_accepts", 32'(acc.size()), 3);
        check("b2b_rsps", 32'(rsp.size()), 3);
        if (acc.size() == 3 && rsp.size() == 3) begin
            check("b2b_gap1", 32'(acc[1] - acc[0]), 2);
            check("b2b_gap2", 32'(acc[2] - acc[1]), 2);
            for (int j = 0; j < 3; j++)
                check($sformatf("b2b_lat%0d", j), 32'(rsp[j] - acc[j]), 2);
        end

        // Reset mid-transfer: bus drops without a clock edge, no response
        cfg_kinds = mk(3,3,3,3);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h200; req_sel = 4'hF; req_dat = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_cyc_before", 32'(cyc_o), 1);
        #2 rst_ni = 1'b0;
        #1 check("mid_cyc_async", 32'(cyc_o), 0);
        check("mid_stb_async", 32'(stb_o), 0);
        check("mid_adr_async", adr_o, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= rsp_valid_o;
        end
        check("mid_no_rsp", 32'(seen), 0);
        rst_ni = 1'b1;
        run_txn(tbl[0], "after_rst");

        // Randomized transfers with termination noise while the bus is idle
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.adr = $urandom; v.sel = 4'($urandom); v.dat = $urandom; v.rdata = $urandom;
            v.wait_n = $urandom_range(0, 9);
            for (int a = 0; a < 4; a++) v.kinds[a] = 3'($urandom_range(0, 6));
            model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
